traffic_phase_ctrl: RTL and testbench

Parametrised N-direction traffic-light controller for an intersection with NUM_DIR approaches. Direction 0 is the main road and rests on green. The other directions are served round-robin on latched sensor requests. Phase timing is in ticks from an internal prescaler, so the same RTL serves board builds (TICK_DIV=50_000_000) and simulation (small TICK_DIV).

---
 rtl/traffic_phase_ctrl.sv | 169 ++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-approach traffic-light controller. Direction 0 is the
// main road and rests on green; side directions are served round-robin on
// latched sensor requests. Phase timing counts ticks from an internal prescaler.
// Optional flashing mode is compiled in with `define FLASH_EN (adds flash_mode).
module traffic_phase_ctrl #(
  parameter int unsigned NUM_DIR   = 2,
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned GREEN_T   = 10,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned TW        = 8,
  localparam int unsigned DW       = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_DIR-1:0]     req,
`ifdef FLASH_EN
  input  logic                   flash_mode,
`endif
  output logic [3*NUM_DIR-1:0]   light,
  output logic [DW-1:0]          green_dir,
  output logic [1:0]             phase,
  output logic                   tick
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [3*NUM_DIR-1:0] LIGHT_RST = {{(NUM_DIR-1){3'b100}}, 3'b001};

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10,
    PH_FLASH  = 2'b11
  } phase_e;

  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick_q, tick_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [NUM_DIR-1:0]   pending_q, pending_d;
  phase_e               phase_q, phase_d;
  logic [DW-1:0]        dir_q, dir_d;
  logic [3*NUM_DIR-1:0] light_q, light_d;
  logic                 flash_on_q, flash_on_d;

  logic [DW-1:0]        nxt_dir;
  logic [2*NUM_DIR-1:0] pend_rot;
  logic                 found;
  logic [NUM_DIR-1:0]   clr_mask;
  logic                 clr_all;

  // Round-robin pick: first pending direction above the current owner, wrapping
  always_comb begin
    pend_rot = {pending_q, pending_q} >> (32'(dir_q) + 32'd1);
    nxt_dir  = '0;
    found    = 1'b0;
    for (int unsigned b = 0; b < NUM_DIR; b++) begin
      if (!found && pend_rot[b]) begin
        found   = 1'b1;
        nxt_dir = DW'((32'(dir_q) + b + 32'd1) % NUM_DIR);
      end
    end
  end

  // Prescaler, phase sequencing, request latching and lamp decode
  always_comb begin
    presc_d    = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
    tick_d     = (presc_d == PW'(TICK_DIV - 1));
    phase_d    = phase_q;
    dir_d      = dir_q;
    timer_d    = timer_q;
    flash_on_d = flash_on_q;
    clr_mask   = '0;
    clr_all    = 1'b0;

    if (tick_q) begin
      // saturate so the main road can rest on green indefinitely
      if (timer_q != '1) timer_d = timer_q + TW'(1);
`ifdef FLASH_EN
      if (flash_mode) begin
        phase_d    = PH_FLASH;
        timer_d    = '0;
        clr_all    = 1'b1;
        flash_on_d = (phase_q == PH_FLASH) ? ~flash_on_q : 1'b1;
      end else
`endif
      begin
        case (phase_q)
          PH_GREEN: begin
            if (dir_q == '0) begin
              if ((timer_q >= TW'(MIN_GREEN - 1)) && (|pending_q)) begin
                phase_d = PH_YELLOW;
                timer_d = '0;
              end
            end else if (timer_q == TW'(GREEN_T - 1)) begin
              phase_d = PH_YELLOW;
              timer_d = '0;
            end
          end
          PH_YELLOW: begin
            if (timer_q == TW'(YELLOW_T - 1)) begin
              phase_d = PH_ALLRED;
              timer_d = '0;
            end
          end
          PH_ALLRED: begin
            if (timer_q == TW'(ALLRED_T - 1)) begin
              phase_d  = PH_GREEN;
              dir_d    = nxt_dir;
              timer_d  = '0;
              clr_mask = NUM_DIR'(1) << nxt_dir;
            end
          end
          default: begin
            // leaving flash always clears through all-red
            phase_d = PH_ALLRED;
            timer_d = '0;
          end
        endcase
      end
    end

    pending_d    = clr_all ? '0 : ((pending_q | req) & ~clr_mask);
    pending_d[0] = 1'b0;

    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      light_d[3*i +: 3] = 3'b100;
      case (phase_d)
        PH_GREEN:  if (DW'(i) == dir_d) light_d[3*i +: 3] = 3'b001;
        PH_YELLOW: if (DW'(i) == dir_d) light_d[3*i +: 3] = 3'b010;
        PH_FLASH: begin
          if (!flash_on_d)  light_d[3*i +: 3] = 3'b000;
          else if (i == 0)  light_d[3*i +: 3] = 3'b010;
          else              light_d[3*i +: 3] = 3'b100;
        end
        default: light_d[3*i +: 3] = 3'b100;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      timer_q    <= '0;
      pending_q  <= '0;
      phase_q    <= PH_GREEN;
      dir_q      <= '0;
      light_q    <= LIGHT_RST;
      flash_on_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      phase_q    <= phase_d;
      dir_q      <= dir_d;
      light_q    <= light_d;
      flash_on_q <= flash_on_d;
    end
  end

  assign light     = light_q;
  assign green_dir = dir_q;
  assign phase     = phase_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with NUM_DIR=3, TICK_DIV=4, GREEN_T=5,
// YELLOW_T=2, ALLRED_T=1, MIN_GREEN=3. Flash scenario built only with FLASH_EN.
module tb_traffic_phase_ctrl;

  localparam logic [8:0] L_G0 = 9'b100_100_001;
  localparam logic [8:0] L_Y0 = 9'b100_100_010;
  localparam logic [8:0] L_AR = 9'b100_100_100;
  localparam logic [8:0] L_G1 = 9'b100_001_100;
  localparam logic [8:0] L_Y1 = 9'b100_010_100;
  localparam logic [8:0] L_G2 = 9'b001_100_100;
  localparam logic [8:0] L_Y2 = 9'b010_100_100;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req   = 3'b000;
`ifdef FLASH_EN
  logic       flash_mode = 1'b0;
`endif
  logic [8:0] light;
  logic [1:0] green_dir;
  logic [1:0] phase;
  logic       tick;

  int errors = 0;
  int checks = 0;

  traffic_phase_ctrl #(
    .NUM_DIR(3), .TICK_DIV(4), .GREEN_T(5), .YELLOW_T(2),
    .ALLRED_T(1), .MIN_GREEN(3), .TW(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
`ifdef FLASH_EN
    .flash_mode(flash_mode),
`endif
    .light(light),
    .green_dir(green_dir),
    .phase(phase),
    .tick(tick)
  );

  always #5 clk = ~clk;

  // Advance to the negedge just after the next tick edge (bounded wait)
  task automatic next_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no tick within %0d cycles", n);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_req(input logic [2:0] r);
    req = r;
    @(negedge clk);
    req = 3'b000;
  endtask

  task automatic test_reset();
    int n;
    int m;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({light, phase, green_dir, tick} !== {L_G0, 2'b00, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got light=%b phase=%b dir=%0d tick=%b, want light=%b phase=00 dir=0 tick=0",
               light, phase, green_dir, tick, L_G0);
    end
    checks++;
    if (dut.pending_q !== 3'b000) begin
      errors++;
      $display("FAIL reset_pending: got %b want 000", dut.pending_q);
    end
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 16);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL first_tick: seen after %0d cycles want 3", n);
    end
    m = 0;
    do begin @(negedge clk); m++; end while (tick !== 1'b1 && m < 16);
    checks++;
    if (m != 4) begin
      errors++;
      $display("FAIL tick_period: got %0d cycles want 4", m);
    end
    @(negedge clk);
    for (int t = 0; t < 100; t++) begin
      next_tick();
      checks++;
      if ({light, phase, green_dir} !== {L_G0, 2'b00, 2'b00}) begin
        errors++;
        $display("FAIL idle_rest tick %0d: got light=%b phase=%b dir=%0d want %b 00 0",
                 t, light, phase, green_dir, L_G0);
      end
    end
  endtask

  task automatic test_single_request();
    logic [12:0] exp_s [12];
    exp_s = '{{L_Y0, 2'b01, 2'd0}, {L_Y0, 2'b01, 2'd0}, {L_AR, 2'b10, 2'd0},
              {L_G1, 2'b00, 2'd1}, {L_G1, 2'b00, 2'd1}, {L_G1, 2'b00, 2'd1},
              {L_G1, 2'b00, 2'd1}, {L_G1, 2'b00, 2'd1}, {L_Y1, 2'b01, 2'd1},
              {L_Y1, 2'b01, 2'd1}, {L_AR, 2'b10, 2'd1}, {L_G0, 2'b00, 2'd0}};
    pulse_req(3'b010);
    for (int s = 0; s < 12; s++) begin
      next_tick();
      checks++;
      if ({light, phase, green_dir} !== exp_s[s]) begin
        errors++;
        $display("FAIL single_req step %0d: got %b_%b_%0d want %b_%b_%0d", s,
                 light, phase, green_dir, exp_s[s][12:4], exp_s[s][3:2], exp_s[s][1:0]);
      end
    end
    for (int s = 0; s < 3; s++) begin
      next_tick();
      checks++;
      if ({light, phase, green_dir} !== {L_G0, 2'b00, 2'd0}) begin
        errors++;
        $display("FAIL single_req_rest %0d: got %b_%b_%0d", s, light, phase, green_dir);
      end
    end
    checks++;
    if (dut.pending_q !== 3'b000) begin
      errors++;
      $display("FAIL single_req_pending: got %b want 000", dut.pending_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp_s [20];
    exp_s = '{{L_Y0, 2'b01, 2'd0}, {L_Y0, 2'b01, 2'd0}, {L_AR, 2'b10, 2'd0},
              {L_G1, 2'b00, 2'd1}, {L_G1, 2'b00, 2'd1}, {L_G1, 2'b00, 2'd1},
              {L_G1, 2'b00, 2'd1}, {L_G1, 2'b00, 2'd1}, {L_Y1, 2'b01, 2'd1},
              {L_Y1, 2'b01, 2'd1}, {L_AR, 2'b10, 2'd1},
              {L_G2, 2'b00, 2'd2}, {L_G2, 2'b00, 2'd2}, {L_G2, 2'b00, 2'd2},
              {L_G2, 2'b00, 2'd2}, {L_G2, 2'b00, 2'd2}, {L_Y2, 2'b01, 2'd2},
              {L_Y2, 2'b01, 2'd2}, {L_AR, 2'b10, 2'd2}, {L_G0, 2'b00, 2'd0}};
    pulse_req(3'b110);
    for (int s = 0; s < 20; s++) begin
      next_tick();
      checks++;
      if ({light, phase, green_dir} !== exp_s[s]) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %b_%b_%0d want %b_%b_%0d", s,
                 light, phase, green_dir, exp_s[s][12:4], exp_s[s][3:2], exp_s[s][1:0]);
      end
    end
  endtask

  task automatic test_min_green();
    logic [12:0] exp_s [6];
    exp_s = '{{L_G0, 2'b00, 2'd0}, {L_G0, 2'b00, 2'd0}, {L_Y0, 2'b01, 2'd0},
              {L_Y0, 2'b01, 2'd0}, {L_AR, 2'b10, 2'd0}, {L_G2, 2'b00, 2'd2}};
    do_reset();
    @(negedge clk);
    pulse_req(3'b100);
    for (int s = 0; s < 6; s++) begin
      next_tick();
      checks++;
      if ({light, phase, green_dir} !== exp_s[s]) begin
        errors++;
        $display("FAIL min_green step %0d: got %b_%b_%0d want %b_%b_%0d", s,
                 light, phase, green_dir, exp_s[s][12:4], exp_s[s][3:2], exp_s[s][1:0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    @(negedge clk);
    pulse_req(3'b010);
    repeat (6) next_tick();
    checks++;
    if ({light, phase, green_dir} !== {L_G1, 2'b00, 2'd1}) begin
      errors++;
      $display("FAIL mid_reset_setup: got %b_%b_%0d want %b_00_1", light, phase, green_dir, L_G1);
    end
    pulse_req(3'b110);
    checks++;
    if (dut.pending_q !== 3'b110) begin
      errors++;
      $display("FAIL mid_reset_latch: got %b want 110", dut.pending_q);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({light, phase, green_dir, tick} !== {L_G0, 2'b00, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_async: got %b_%b_%0d tick=%b want %b_00_0 tick=0",
               light, phase, green_dir, tick, L_G0);
    end
    checks++;
    if (dut.pending_q !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_pending: got %b want 000", dut.pending_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 12; s++) begin
      next_tick();
      checks++;
      if ({light, phase, green_dir} !== {L_G0, 2'b00, 2'd0}) begin
        errors++;
        $display("FAIL mid_reset_rest %0d: got %b_%b_%0d want %b_00_0", s, light, phase, green_dir, L_G0);
      end
    end
  endtask

`ifdef FLASH_EN
  task automatic test_flash();
    logic [10:0] exp_s [5];
    exp_s = '{{9'b100_100_010, 2'b11}, {9'b000_000_000, 2'b11},
              {9'b100_100_010, 2'b11}, {L_AR, 2'b10}, {L_G0, 2'b00}};
    do_reset();
    @(negedge clk);
    pulse_req(3'b100);
    repeat (6) next_tick();
    checks++;
    if ({light, phase, green_dir} !== {L_G2, 2'b00, 2'd2}) begin
      errors++;
      $display("FAIL flash_setup: got %b_%b_%0d want %b_00_2", light, phase, green_dir, L_G2);
    end
    pulse_req(3'b010);
    flash_mode = 1'b1;
    for (int s = 0; s < 5; s++) begin
      if (s == 3) flash_mode = 1'b0;
      next_tick();
      checks++;
      if ({light, phase} !== exp_s[s]) begin
        errors++;
        $display("FAIL flash step %0d: got %b_%b want %b_%b", s, light, phase,
                 exp_s[s][10:2], exp_s[s][1:0]);
      end
      if (s == 0) begin
        checks++;
        if (dut.pending_q !== 3'b000) begin
          errors++;
          $display("FAIL flash_pending: got %b want 000", dut.pending_q);
        end
      end
    end
    checks++;
    if (green_dir !== 2'd0) begin
      errors++;
      $display("FAIL flash_resume_dir: got %0d want 0", green_dir);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_request();
    test_back_to_back();
    test_min_green();
    test_mid_reset();
`ifdef FLASH_EN
    test_flash();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
